// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester ports (p0 = instruction,
//               p1 = data) and the single-ported word memory bus served by
//               mem_arbiter.
//               slave  : arbiter view (requests and mem_rdata in,
//                        responses and memory controls out)
//               master : environment view (requesters plus memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
) ();
  // port 0 (instruction)
  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic                  p0_req_wen;
  logic [ADDR_WIDTH-1:0] p0_req_addr;
  logic [31:0]           p0_req_wdata;
  logic                  p0_resp_valid;
  logic                  p0_resp_ready;
  logic [31:0]           p0_resp_rdata;
  // port 1 (data)
  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic                  p1_req_wen;
  logic [ADDR_WIDTH-1:0] p1_req_addr;
  logic [31:0]           p1_req_wdata;
  logic                  p1_resp_valid;
  logic                  p1_resp_ready;
  logic [31:0]           p1_resp_rdata;
  // memory side
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  mem_wren;
  logic                  mem_rden;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  p0_req_valid, p0_req_wen, p0_req_addr, p0_req_wdata, p0_resp_ready,
    input  p1_req_valid, p1_req_wen, p1_req_addr, p1_req_wdata, p1_resp_ready,
    input  mem_rdata,
    output p0_req_ready, p0_resp_valid, p0_resp_rdata,
    output p1_req_ready, p1_resp_valid, p1_resp_rdata,
    output mem_waddr, mem_raddr, mem_wren, mem_rden, mem_wdata
  );

  modport master (
    output p0_req_valid, p0_req_wen, p0_req_addr, p0_req_wdata, p0_resp_ready,
    output p1_req_valid, p1_req_wen, p1_req_addr, p1_req_wdata, p1_resp_ready,
    output mem_rdata,
    input  p0_req_ready, p0_resp_valid, p0_resp_rdata,
    input  p1_req_ready, p1_resp_valid, p1_resp_rdata,
    input  mem_waddr, mem_raddr, mem_wren, mem_rden, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single word
//               memory with combinational read data. One transaction is in
//               flight at a time; its response is held until the owner
//               consumes it, and a new grant may be issued in that same
//               handshake cycle (back-to-back).
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mem_arbiter_if.slave (p0/p1 request/response ports
//                       and memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  w_owner_nxt;
  logic                  r_last_grant;
  logic                  w_last_grant_nxt;
  logic [31:0]           r_resp_data;
  logic [31:0]           w_resp_data_nxt;

  logic                  w_handshake;
  logic                  w_accept;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_sel_wen;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      // Starting at 1 makes port 0 win the first contested cycle.
      r_last_grant <= 1'b1;
      r_resp_data  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_resp_data  <= w_resp_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_resp_data_nxt  = r_resp_data;
    bus.mem_wren     = 1'b0;
    bus.mem_rden     = 1'b0;
    bus.mem_waddr    = '0;
    bus.mem_raddr    = '0;
    bus.mem_wdata    = 32'h0;

    // The owner's response is consumed this cycle.
    w_handshake = (r_state == RESP) &&
                  (r_owner ? bus.p1_resp_ready : bus.p0_resp_ready);
    // rst_n gating keeps req_ready and memory controls low during reset,
    // since both are combinational.
    w_accept = rst_n && ((r_state == IDLE) || w_handshake);

    // On contention the port that did not win last time is served.
    w_grant0 = w_accept && bus.p0_req_valid && (!bus.p1_req_valid ||  r_last_grant);
    w_grant1 = w_accept && bus.p1_req_valid && (!bus.p0_req_valid || !r_last_grant);

    w_sel_wen   = w_grant1 ? bus.p1_req_wen   : bus.p0_req_wen;
    w_sel_addr  = w_grant1 ? bus.p1_req_addr  : bus.p0_req_addr;
    w_sel_wdata = w_grant1 ? bus.p1_req_wdata : bus.p0_req_wdata;

    if (w_grant0 || w_grant1) begin
      if (w_sel_wen) begin
        bus.mem_wren  = 1'b1;
        bus.mem_waddr = w_sel_addr;
        bus.mem_wdata = w_sel_wdata;
      end else begin
        bus.mem_rden  = 1'b1;
        bus.mem_raddr = w_sel_addr;
      end
      w_state_nxt      = RESP;
      w_owner_nxt      = w_grant1;
      w_last_grant_nxt = w_grant1;
      w_resp_data_nxt  = w_sel_wen ? 32'h0 : bus.mem_rdata;
    end else if (w_handshake) begin
      w_state_nxt     = IDLE;
      w_resp_data_nxt = 32'h0;
    end
  end

  assign bus.p0_req_ready  = w_grant0;
  assign bus.p1_req_ready  = w_grant1;
  assign bus.p0_resp_valid = (r_state == RESP) && !r_owner;
  assign bus.p1_resp_valid = (r_state == RESP) &&  r_owner;
  assign bus.p0_resp_rdata = bus.p0_resp_valid ? r_resp_data : 32'h0;
  assign bus.p1_resp_rdata = bus.p1_resp_valid ? r_resp_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed vectors with
//               hand-computed expectations, then random traffic on both
//               ports scored against a reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Memory with combinational read and a preload path used only while idle.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;
  assign bus.mem_rdata = bus.mem_rden ? mem[bus.mem_raddr] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_wren)  mem[bus.mem_waddr] <= bus.mem_wdata;
    else if (pre_we)   mem[pre_addr]      <= pre_data;
  end

  logic [31:0] ref_mem [0:15];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input logic wen,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      bus.p0_req_valid = v; bus.p0_req_wen = wen;
      bus.p0_req_addr  = addr; bus.p0_req_wdata = wd;
    end else begin
      bus.p1_req_valid = v; bus.p1_req_wen = wen;
      bus.p1_req_addr  = addr; bus.p1_req_wdata = wd;
    end
  endtask

  // random-phase state
  logic          pend   [2];
  logic          pwen   [2];
  logic [AW-1:0] paddr  [2];
  logic [31:0]   pwd    [2];
  int            losses [2];
  logic [31:0]   expq0 [$];
  logic [31:0]   expq1 [$];
  logic          rdy [2];
  logic          rv  [2];
  logic          rr  [2];
  logic [31:0]   rd  [2];
  logic [31:0]   e;

  initial begin
    rst_n = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = 32'h0;
    drive(0, 1'b1, 1'b0, '0, 32'h0);
    drive(1, 1'b1, 1'b0, '0, 32'h0);
    bus.p0_resp_ready = 1'b1;
    bus.p1_resp_ready = 1'b1;

    // Preload words 0..15 while held in reset (requests present but ignored).
    for (int i = 0; i < 16; i++) begin
      pre_we   = 1'b1;
      pre_addr = AW'(i);
      pre_data = (i == 5) ? 32'hDEADBEEF : (32'hA5A50000 + 32'(i));
      ref_mem[i] = pre_data;
      next_cycle();
    end
    pre_we = 1'b0;
    sample();
    check("rst_p0_req_ready", bus.p0_req_ready, 0);
    check("rst_p1_req_ready", bus.p1_req_ready, 0);
    check("rst_p0_resp_valid", bus.p0_resp_valid, 0);
    check("rst_p1_resp_valid", bus.p1_resp_valid, 0);
    check("rst_mem_rden", bus.mem_rden, 0);
    check("rst_mem_wren", bus.mem_wren, 0);
    check("rst_mem_raddr", 32'(bus.mem_raddr), 0);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    rst_n = 1'b1;
    next_cycle();
    sample();
    check("idle_mem_rden", bus.mem_rden, 0);
    check("idle_p0_resp_valid", bus.p0_resp_valid, 0);

    // p1 read of address 5
    next_cycle();
    drive(1, 1'b1, 1'b0, 10'd5, 32'h0);
    sample();
    check("rd5_p1_req_ready", bus.p1_req_ready, 1);
    check("rd5_p0_req_ready", bus.p0_req_ready, 0);
    check("rd5_mem_rden", bus.mem_rden, 1);
    check("rd5_mem_raddr", 32'(bus.mem_raddr), 5);
    check("rd5_mem_wren", bus.mem_wren, 0);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    sample();
    check("rd5_p1_resp_valid", bus.p1_resp_valid, 1);
    check("rd5_p1_resp_rdata", bus.p1_resp_rdata, 32'hDEADBEEF);
    check("rd5_p0_resp_valid", bus.p0_resp_valid, 0);
    check("rd5_p0_resp_rdata", bus.p0_resp_rdata, 0);

    // Continuous contention: p1 won last, so grants go 0,1,0,1.
    next_cycle();
    drive(0, 1'b1, 1'b0, 10'd2, 32'h0);
    drive(1, 1'b1, 1'b0, 10'd3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("alt%0d_p0_req_ready", i), bus.p0_req_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_p1_req_ready", i), bus.p1_req_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) begin
        check($sformatf("alt%0d_p0_resp_valid", i), bus.p0_resp_valid, 1);
        check($sformatf("alt%0d_p0_resp_rdata", i), bus.p0_resp_rdata, 32'hA5A50002);
      end else if (i > 0) begin
        check($sformatf("alt%0d_p1_resp_valid", i), bus.p1_resp_valid, 1);
        check($sformatf("alt%0d_p1_resp_rdata", i), bus.p1_resp_rdata, 32'hA5A50003);
      end
      next_cycle();
    end
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    sample();
    check("alt_last_p1_resp_valid", bus.p1_resp_valid, 1);
    check("alt_last_p1_resp_rdata", bus.p1_resp_rdata, 32'hA5A50003);

    // p1 write to 9, then p0 read of 9 accepted back-to-back.
    next_cycle();
    drive(1, 1'b1, 1'b1, 10'd9, 32'h12345678);
    sample();
    check("wr9_p1_req_ready", bus.p1_req_ready, 1);
    check("wr9_mem_wren", bus.mem_wren, 1);
    check("wr9_mem_waddr", 32'(bus.mem_waddr), 9);
    check("wr9_mem_wdata", bus.mem_wdata, 32'h12345678);
    check("wr9_mem_rden", bus.mem_rden, 0);
    ref_mem[9] = 32'h12345678;
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    drive(0, 1'b1, 1'b0, 10'd9, 32'h0);
    sample();
    check("wr9_p1_resp_valid", bus.p1_resp_valid, 1);
    check("wr9_p1_resp_rdata", bus.p1_resp_rdata, 0);
    check("rd9_p0_req_ready", bus.p0_req_ready, 1);
    check("rd9_mem_raddr", 32'(bus.mem_raddr), 9);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    sample();
    check("rd9_p0_resp_valid", bus.p0_resp_valid, 1);
    check("rd9_p0_resp_rdata", bus.p0_resp_rdata, 32'h12345678);

    // p0 response stalled 4 cycles while p1 waits.
    next_cycle();
    drive(0, 1'b1, 1'b0, 10'd5, 32'h0);
    bus.p0_resp_ready = 1'b0;
    sample();
    check("stall_p0_req_ready", bus.p0_req_ready, 1);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    drive(1, 1'b1, 1'b0, 10'd2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("stall%0d_p0_resp_valid", k), bus.p0_resp_valid, 1);
      check($sformatf("stall%0d_p0_resp_rdata", k), bus.p0_resp_rdata, 32'hDEADBEEF);
      check($sformatf("stall%0d_p1_req_ready", k), bus.p1_req_ready, 0);
      check($sformatf("stall%0d_p1_resp_valid", k), bus.p1_resp_valid, 0);
      next_cycle();
    end
    bus.p0_resp_ready = 1'b1;
    sample();
    check("stall_hs_p1_req_ready", bus.p1_req_ready, 1);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    sample();
    check("stall_p1_resp_rdata", bus.p1_resp_rdata, 32'hA5A50002);
    check("stall_p0_resp_valid_after", bus.p0_resp_valid, 0);

    // Reset during an outstanding write response.
    next_cycle();
    drive(1, 1'b1, 1'b1, 10'd11, 32'hCAFEF00D);
    bus.p1_resp_ready = 1'b0;
    sample();
    check("wr11_p1_req_ready", bus.p1_req_ready, 1);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    drive(0, 1'b1, 1'b0, 10'd3, 32'h0);
    ref_mem[11] = 32'hCAFEF00D;
    sample();
    check("wr11_p1_resp_valid", bus.p1_resp_valid, 1);
    check("wr11_p0_req_ready_blocked", bus.p0_req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_p1_resp_valid", bus.p1_resp_valid, 0);
    check("arst_p0_req_ready", bus.p0_req_ready, 0);
    check("arst_mem_rden", bus.mem_rden, 0);
    next_cycle();
    rst_n = 1'b1;
    bus.p1_resp_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 10'd11, 32'h0);
    drive(1, 1'b1, 1'b0, 10'd3, 32'h0);
    sample();
    check("post_rst_p0_req_ready", bus.p0_req_ready, 1);
    check("post_rst_p1_req_ready", bus.p1_req_ready, 0);
    check("post_rst_mem_raddr", 32'(bus.mem_raddr), 11);
    next_cycle();
    sample();
    check("post_rst_p0_resp_rdata", bus.p0_resp_rdata, 32'hCAFEF00D);
    check("post_rst_p1_req_ready", bus.p1_req_ready, 1);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    sample();
    check("post_rst_p1_resp_rdata", bus.p1_resp_rdata, 32'hA5A50003);

    // Random traffic on addresses 0..15 against the reference memory.
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwen[p] = 1'b0; paddr[p] = '0; pwd[p] = 32'h0; losses[p] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 2 == 0)) begin
          pend[p]  = 1'b1;
          pwen[p]  = 1'($urandom % 2);
          paddr[p] = AW'($urandom % 16);
          pwd[p]   = $urandom;
        end
        drive(p, pend[p], pwen[p], paddr[p], pwd[p]);
      end
      bus.p0_resp_ready = ($urandom % 4) != 0;
      bus.p1_resp_ready = ($urandom % 4) != 0;
      sample();
      rdy[0] = bus.p0_req_ready;  rdy[1] = bus.p1_req_ready;
      rv[0]  = bus.p0_resp_valid; rv[1]  = bus.p1_resp_valid;
      rr[0]  = bus.p0_resp_ready; rr[1]  = bus.p1_resp_ready;
      rd[0]  = bus.p0_resp_rdata; rd[1]  = bus.p1_resp_rdata;
      check("rnd_single_grant", rdy[0] & rdy[1], 0);
      check("rnd_single_resp", rv[0] & rv[1], 0);
      // Responses consumed this cycle belong to earlier grants.
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && rr[p]) begin
          if (p == 0) begin
            check("rnd_p0_resp_expected", expq0.size(), 1);
            e = (expq0.size() > 0) ? expq0.pop_front() : 32'h0;
          end else begin
            check("rnd_p1_resp_expected", expq1.size(), 1);
            e = (expq1.size() > 0) ? expq1.pop_front() : 32'h0;
          end
          check($sformatf("rnd_p%0d_rdata", p), rd[p], e);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          check($sformatf("rnd_p%0d_grant_pending", p), pend[p], 1);
          check($sformatf("rnd_p%0d_wait_windows", p), (losses[p] <= 1) ? 1 : 0, 1);
          e = pwen[p] ? 32'h0 : ref_mem[paddr[p][3:0]];
          if (pwen[p]) ref_mem[paddr[p][3:0]] = pwd[p];
          if (p == 0) expq0.push_back(e); else expq1.push_back(e);
          pend[p]   = 1'b0;
          losses[p] = 0;
        end else if (pend[p] && rdy[1-p]) begin
          losses[p]++;
        end
      end
    end
    // Drain outstanding responses.
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 32'h0);
    bus.p0_resp_ready = 1'b1;
    bus.p1_resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (bus.p0_resp_valid) begin
        e = (expq0.size() > 0) ? expq0.pop_front() : 32'h0;
        check("drain_p0_rdata", bus.p0_resp_rdata, e);
      end
      if (bus.p1_resp_valid) begin
        e = (expq1.size() > 0) ? expq1.pop_front() : 32'h0;
        check("drain_p1_rdata", bus.p1_resp_rdata, e);
      end
      next_cycle();
    end
    check("drain_p0_queue_empty", expq0.size(), 0);
    check("drain_p1_queue_empty", expq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
